// File: rtl/demux_1to16_tdm.sv
// Time-division 1-to-16 demultiplexer: steers a serial bit stream into a 16-bit
// word, aligned to slot 0 by a frame-sync input, and strobes each completed word.
//
// state   | meaning
// IDLE    | waiting for a valid start; other valid bits are dropped
// COLLECT | frame in progress, slot holds the next slot index
module demux_1to16_tdm #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in,
   input  logic        valid,
   input  logic        start,
   output logic [15:0] out,
   output logic        frame_valid,
   output logic        sync_err,
   output logic        busy,
   output logic [3:0]  slot
);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t      state;
   logic [15:0] sh;
   logic [15:0] sh_slot0;
   logic [15:0] sh_slotk;
   logic [3:0]  pos_0;
   logic [3:0]  pos_k;

   // Shadow contents with the current bit merged, for a slot-0 write and for
   // a write at the current slot; the latter is also the completed word.
   always_comb begin
      pos_0    = LSB_FIRST ? 4'd0 : 4'd15;
      pos_k    = LSB_FIRST ? slot : ~slot;
      sh_slot0 = sh;
      sh_slot0[pos_0] = in;
      sh_slotk = sh;
      sh_slotk[pos_k] = in;
   end

   assign busy = (state == COLLECT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sh          <= 16'h0000;
         slot        <= 4'd0;
         out         <= 16'h0000;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (valid && start) begin
                  sh    <= sh_slot0;
                  slot  <= 4'd1;
                  state <= COLLECT;
               end
            end
            COLLECT: begin
               if (valid) begin
                  if (start) begin
                     // Resync: partial frame abandoned, this bit becomes slot 0.
                     sh       <= sh_slot0;
                     slot     <= 4'd1;
                     sync_err <= 1'b1;
                  end else begin
                     sh   <= sh_slotk;
                     slot <= slot + 4'd1;
                     if (slot == 4'd15) begin
                        out         <= sh_slotk;
                        frame_valid <= 1'b1;
                        state       <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_demux_1to16_tdm.sv
// Directed bench for demux_1to16_tdm: one instance per bit order, fed the same
// stream, checked against hand-computed words and cycle-level expectations.
module tb_demux_1to16_tdm;

   logic        clk = 1'b0;
   logic        rst, din, valid, start;
   logic [15:0] out_l, out_m;
   logic        fv_l, fv_m, se_l, se_m, busy_l, busy_m;
   logic [3:0]  slot_l, slot_m;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int last_fv_cyc = 0;

   always #5 clk = ~clk;

   demux_1to16_tdm #(.LSB_FIRST(1'b1)) dut_l (
      .clk(clk), .rst(rst), .in(din), .valid(valid), .start(start),
      .out(out_l), .frame_valid(fv_l), .sync_err(se_l), .busy(busy_l), .slot(slot_l));

   demux_1to16_tdm #(.LSB_FIRST(1'b0)) dut_m (
      .clk(clk), .rst(rst), .in(din), .valid(valid), .start(start),
      .out(out_m), .frame_valid(fv_m), .sync_err(se_m), .busy(busy_m), .slot(slot_m));

   typedef struct {
      logic [15:0] bits;    // bit k is the value sent in slot k
      logic [15:0] exp_l;
      logic [15:0] exp_m;
      bit          gaps;
      bit          b2b;     // check 16-cycle spacing from previous frame_valid
      bit          do_mux;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic s, input logic b);
      @(negedge clk);
      rst = r; valid = v; start = s; din = b;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send_frame(input logic [15:0] bits, input logic [15:0] exp_l,
                             input logic [15:0] exp_m, input bit gaps, input bit resync);
      logic [15:0] prev_l, prev_m;
      int  total, t0, n, bad;
      prev_l = out_l;
      prev_m = out_m;
      total  = 0;
      bad    = 0;
      t0     = cyc;
      for (int k = 0; k < 16; k++) begin
         if (gaps && k > 0) begin
            n = int'($urandom_range(0, 2));
            for (int g = 0; g < n; g++) begin
               drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
               if (fv_l || fv_m || se_l || se_m || out_l !== prev_l || out_m !== prev_m ||
                   slot_l != 4'(k) || slot_m != 4'(k) || !busy_l || !busy_m) bad++;
            end
            total += n;
         end
         drive(1'b0, 1'b1, (k == 0), bits[k]);
         if (k == 0) check("sync_err_at_start", {30'd0, se_l, se_m}, resync ? 32'd3 : 32'd0);
         if (k < 15) begin
            if (fv_l || fv_m || out_l !== prev_l || out_m !== prev_m ||
                slot_l != 4'(k + 1) || slot_m != 4'(k + 1) || !busy_l || !busy_m) bad++;
            if (k > 0 && (se_l || se_m)) bad++;
         end
      end
      check("mid_frame_violations", bad, 0);
      check("frame_valid_end", {30'd0, fv_l, fv_m}, 32'd3);
      check("out_lsb_first", {16'd0, out_l}, {16'd0, exp_l});
      check("out_msb_first", {16'd0, out_m}, {16'd0, exp_m});
      check("idle_after_frame", {22'd0, se_l, se_m, busy_l, busy_m, slot_l, slot_m}, 32'd0);
      check("frame_latency", cyc - t0, 16 + total);
      last_fv_cyc = cyc;
   endtask

   initial begin
      logic [15:0] w;
      logic [15:0] prev;
      logic [3:0]  mux_sel [4];
      logic        mux_exp [4];
      int          prev_fv;

      mux_sel = '{4'h0, 4'h1, 4'h6, 4'hc};
      mux_exp = '{1'b0, 1'b1, 1'b0, 1'b1};

      vecs[0] = '{16'h3f0a, 16'h3f0a, 16'h50fc, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{16'h3f0a, 16'h3f0a, 16'h50fc, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{16'h1234, 16'h1234, 16'h2c48, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{16'hfedc, 16'hfedc, 16'h3b7f, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{16'ha5a5, 16'ha5a5, 16'ha5a5, 1'b0, 1'b1, 1'b0};

      rst = 1'b1; valid = 1'b0; start = 1'b0; din = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("reset_out", {out_l, out_m}, 32'd0);
      check("reset_flags", {22'd0, fv_l, fv_m, se_l, se_m, busy_l, busy_m, slot_l, slot_m}, 32'd0);

      // Valid bits without start in IDLE, and start without valid, change nothing.
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      check("idle_bits_ignored", {6'd0, fv_l, fv_m, busy_l, busy_m, slot_l, slot_m, out_l},
            32'd0);

      for (int i = 0; i < 5; i++) begin
         prev_fv = last_fv_cyc;
         send_frame(vecs[i].bits, vecs[i].exp_l, vecs[i].exp_m, vecs[i].gaps, 1'b0);
         if (vecs[i].b2b) check("back_to_back_spacing", last_fv_cyc - prev_fv, 16);
         if (vecs[i].do_mux)
            for (int s = 0; s < 4; s++)
               check("mux16to1_view", {31'd0, out_l[mux_sel[s]]}, {31'd0, mux_exp[s]});
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("frame_valid_one_cycle", {30'd0, fv_l, fv_m}, 32'd0);

      // Resync: 7 bits of a frame, then a new start followed by 16'ha5a5.
      send_frame(16'h3f0a, 16'h3f0a, 16'h50fc, 1'b0, 1'b0);
      w = 16'h00ff;
      for (int k = 0; k < 7; k++) drive(1'b0, 1'b1, (k == 0), w[k]);
      check("partial_no_err", {28'd0, se_l, se_m, fv_l, fv_m}, 32'd0);
      check("partial_slot", {24'd0, slot_l, slot_m}, 32'h77);
      send_frame(16'ha5a5, 16'ha5a5, 16'ha5a5, 1'b0, 1'b1);

      // Start on the completing slot-15 cycle is a resync, not a frame.
      w = 16'hffff;
      for (int k = 0; k < 15; k++) drive(1'b0, 1'b1, (k == 0), w[k]);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      check("slot15_start_flags", {28'd0, se_l, se_m, fv_l, fv_m}, 32'hc);
      check("slot15_start_state", {22'd0, busy_l, busy_m, slot_l, slot_m}, 32'h311);
      check("slot15_start_out_held", {out_l, out_m}, 32'ha5a5_a5a5);
      w = 16'h0f0e;
      for (int k = 1; k < 16; k++) drive(1'b0, 1'b1, 1'b0, w[k]);
      check("resync_frame_valid", {30'd0, fv_l, fv_m}, 32'd3);
      check("resync_frame_out", {out_l, out_m}, 32'h0f0e_70f0);

      // Reset at slot 9, asserted together with valid and start.
      prev = 16'hffff;
      for (int k = 0; k < 9; k++) drive(1'b0, 1'b1, (k == 0), prev[k]);
      check("pre_reset_slot", {24'd0, slot_l, slot_m}, 32'h99);
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      check("mid_reset_state",
            {10'd0, fv_l, fv_m, se_l, se_m, busy_l, busy_m, slot_l, slot_m, 8'd0}, 32'd0);
      check("mid_reset_out", {out_l, out_m}, 32'd0);
      send_frame(16'h1234, 16'h1234, 16'h2c48, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/demux_1to16_tdm.md
# demux_1to16_tdm

Time-division 1-to-16 demultiplexer. It is the receive-side counterpart of the 16-to-1 selector: it takes a serial bit stream, one bit per valid cycle, and steers consecutive bits into 16 output lanes. It presents the completed 16-bit word with a one-cycle strobe. A frame-sync input aligns slot 0, so that for every k, `mux16to1` with `sel = k` applied to `out` returns the bit sent in slot k.

## Interface
Parameters:
- LSB_FIRST, 1, slot k maps to out[k] when 1 and to out[15-k] when 0

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in  input  1  serial data bit for the current slot
- valid  input  1  `in` carries a slot bit this cycle
- start  input  1  frame sync, qualified by `valid`; marks the current bit as slot 0
- out  output  16  last completed frame, held until the next frame completes
- frame_valid  output  1  one-cycle strobe: `out` was updated this cycle
- sync_err  output  1  one-cycle strobe: frame aborted by an early `start`
- busy  output  1  frame in progress (state COLLECT)
- slot  output  4  index of the next slot to be written

## Operation
- Internal state: shadow register sh[15:0], slot counter slot[3:0], FSM {IDLE, COLLECT}.
- Bit placement: bit for slot k is written to sh[k] when LSB_FIRST=1, otherwise to sh[15-k].
- IDLE:
  - valid=1, start=1: write in to slot 0, slot←1, go to COLLECT.
  - valid=1, start=0: the bit is dropped; state and slot are unchanged.
  - valid=0: no action; start is ignored.
- COLLECT, valid=1, start=0:
  - Write in to sh[slot]; slot←slot+1.
  - If slot==15: the word made of sh with the final bit merged is loaded into out; frame_valid←1; slot←0 (4-bit wrap); go to IDLE.
- COLLECT, valid=1, start=1 (resync):
  - The partial frame is discarded; out is not updated; sync_err←1.
  - The bit is written as slot 0; slot←1; stay in COLLECT.
  - Stale sh bits are overwritten as the new frame fills.
- COLLECT, valid=0: hold all state; gaps of any length are allowed between bits.
- Back-to-back frames: start on the cycle after the completing bit is accepted normally from IDLE, with no dead cycle.
- busy = (state==COLLECT). slot is the registered counter.
- Reset (rst=1 at a clock edge), regardless of state, mid-frame included:
  - out=16'h0000, frame_valid=0, sync_err=0, busy=0, slot=0, sh=0, state IDLE.
  - Any partial frame is lost.
  - rst has priority over valid and start in the same cycle.

## Timing
- All outputs are registered and change only on the rising edge of clk.
- Latency: out and frame_valid update at the edge that samples the slot-15 bit, i.e. visible in the cycle after the bit is presented.
- Minimum frame length: 16 consecutive valid cycles from start to frame_valid.
- frame_valid and sync_err are exactly one cycle wide. Both cannot be asserted in the same cycle.
- start on a completing slot-15 cycle is treated as resync: sync_err, no frame_valid.
- Throughput: one bit per clock; one frame per 16 valid cycles sustained.

## Test plan
- Reset: assert rst 2 cycles -> out=16'h0000, frame_valid=0, sync_err=0, busy=0, slot=0.
- Frame 16'h3f0a, LSB_FIRST=1:
  - Stimulus: start with the first bit, then bits 0,1,0,1,0,0,0,0,1,1,1,1,1,1,0,0 on consecutive valid cycles.
  - Response: out=16'h3f0a with a one-cycle frame_valid after the 16th bit; feeding out to mux16to1 with sel=0,1,6,c gives 0,1,0,1.
- Same bit stream with LSB_FIRST=0 -> out=16'h50fc. Same stream with random valid gaps -> identical out, with frame_valid delayed by the gap count.
- Resync:
  - Stimulus: start, 7 bits, then start again, followed by the 16 bits of 16'ha5a5.
  - Response: sync_err pulses once at the second start; out stays at its previous value; then out=16'ha5a5 with a single frame_valid.
- Idle bits and mid-frame reset:
  - Valid bits without start in IDLE -> no state change, slot stays 0.
  - rst at slot 9 -> slot=0, busy=0, out=0; the next full frame is received correctly.
- Back-to-back frames: 16'h1234 then 16'hfedc with no idle cycles -> two frame_valid pulses 16 cycles apart, with the correct out values.
